// File: rtl/uart_pkg.sv
// Shared constants, bit-timing helpers and FSM state types for uart_shift_link.
package uart_pkg;

  localparam int CLK_HZ    = 50_000_000;
  localparam int BAUD      = 115200;
  localparam int HDR_WIDTH = 640;

  // Bit period in clocks, truncated.
  function automatic int calc_bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Half a bit period; used to land the start-bit check mid-bit.
  function automatic int calc_half_cyc(input int clk_hz, input int baud);
    return calc_bit_cyc(clk_hz, baud) / 2;
  endfunction

  localparam int BIT_CYC  = calc_bit_cyc(CLK_HZ, BAUD);
  localparam int HALF_CYC = calc_half_cyc(CLK_HZ, BAUD);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_shift_link_shift_reg.sv
// Byte accumulator: shifts INPUT_WIDTH bits in at the LSB end on load.
// reset is active-low and asynchronous, matching the top-level reset.
module shift_reg #(
  parameter int INPUT_WIDTH = 8,
  parameter int DATA_WIDTH  = 640
) (
  output logic [DATA_WIDTH-1:0]  data_out,
  input  logic [INPUT_WIDTH-1:0] data_in,
  input  logic                   clock,
  input  logic                   load,
  input  logic                   shift_byte,
  input  logic                   reset
);

  logic [DATA_WIDTH-1:0] loaded;

  generate
    if (INPUT_WIDTH == DATA_WIDTH) begin : g_full
      assign loaded = data_in;
    end else begin : g_part
      assign loaded = {data_out[DATA_WIDTH-INPUT_WIDTH-1:0], data_in};
    end
  endgenerate

  // Accumulator register; load wins over the zero-fill byte shift.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= loaded;
    end else if (shift_byte) begin
      data_out <= {data_out[DATA_WIDTH-9:0], 8'h00};
    end
  end

endmodule

// File: rtl/uart_shift_link.sv
// uart_shift_link: 8N1 UART transceiver with a receive-side header accumulator.
// Optional macro UART_RX_SYNC_EN: adds a 2-flop synchronizer on rx (2 cycles latency).
//
// state    | meaning
// TX_IDLE  | line high, waiting for wr_en
// TX_START | driving start bit (0)
// TX_DATA  | driving 8 data bits LSB first
// TX_STOP  | driving stop bit (1)
// RX_IDLE  | waiting for a low on rx
// RX_START | waiting half a bit to confirm the start bit
// RX_DATA  | sampling 8 data bits mid-bit
// RX_STOP  | sampling the stop bit; good stop delivers the byte
module uart_shift_link #(
  parameter int CLK_HZ    = uart_pkg::CLK_HZ,
  parameter int BAUD      = uart_pkg::BAUD,
  parameter int HDR_WIDTH = uart_pkg::HDR_WIDTH
) (
  input  logic                 clk_50m,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [7:0]           din,
  input  logic                 wr_en,
  output logic                 tx_busy,
  output logic [7:0]           dout,
  output logic                 rdy,
  input  logic                 rdy_clr,
  output logic [HDR_WIDTH-1:0] header_data
);
  import uart_pkg::*;

  localparam int BIT_N  = calc_bit_cyc(CLK_HZ, BAUD);
  localparam int HALF_N = calc_half_cyc(CLK_HZ, BAUD);
  localparam int CNT_W  = $clog2(BIT_N + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_N - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  tx_state_t        tx_state, tx_state_nx;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]       tx_idx, tx_idx_nx;
  logic [7:0]       tx_shift, tx_shift_nx;

  rx_state_t        rx_state, rx_state_nx;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]       rx_idx, rx_idx_nx;
  logic [7:0]       rx_byte, rx_byte_nx;
  logic             rx_s;
  logic             load;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;

  // Two-flop synchronizer, idles high so reset does not look like a start bit.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx};
  end
  assign rx_s = rx_sync[1];
`else
  assign rx_s = rx;
`endif

  // Transmit FSM state, bit timer, bit index and latched byte.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_idx   <= tx_idx_nx;
      tx_shift <= tx_shift_nx;
    end
  end

  // Transmit next-state and line drive; tx is decoded straight from state.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_idx_nx   = tx_idx;
    tx_shift_nx = tx_shift;
    tx          = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (wr_en) begin
          tx_state_nx = TX_START;
          tx_cnt_nx   = BIT_LAST;
          tx_shift_nx = din;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (tx_cnt == '0) begin
          tx_state_nx = TX_DATA;
          tx_cnt_nx   = BIT_LAST;
          tx_idx_nx   = '0;
        end else begin
          tx_cnt_nx = tx_cnt - CNT_ONE;
        end
      end
      TX_DATA: begin
        tx = tx_shift[0];
        if (tx_cnt == '0) begin
          tx_cnt_nx   = BIT_LAST;
          tx_shift_nx = {1'b0, tx_shift[7:1]};
          if (tx_idx == 3'd7) tx_state_nx = TX_STOP;
          else                tx_idx_nx   = tx_idx + 3'd1;
        end else begin
          tx_cnt_nx = tx_cnt - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) tx_state_nx = TX_IDLE;
        else              tx_cnt_nx   = tx_cnt - CNT_ONE;
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // Receive FSM state, sample timer, bit index and assembling byte.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_idx   <= rx_idx_nx;
      rx_byte  <= rx_byte_nx;
    end
  end

  // Receive next-state; load pulses for one cycle on a good stop bit.
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_idx_nx   = rx_idx;
    rx_byte_nx  = rx_byte;
    load        = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_nx = RX_START;
          rx_cnt_nx   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_s) begin
            rx_state_nx = RX_IDLE;
          end else begin
            rx_state_nx = RX_DATA;
            rx_cnt_nx   = BIT_LAST;
            rx_idx_nx   = '0;
          end
        end else begin
          rx_cnt_nx = rx_cnt - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_cnt_nx  = BIT_LAST;
          rx_byte_nx = {rx_s, rx_byte[7:1]};
          if (rx_idx == 3'd7) rx_state_nx = RX_STOP;
          else                rx_idx_nx   = rx_idx + 3'd1;
        end else begin
          rx_cnt_nx = rx_cnt - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          load        = rx_s;
          rx_state_nx = RX_IDLE;
        end else begin
          rx_cnt_nx = rx_cnt - CNT_ONE;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // Delivered byte and sticky ready; a new byte beats a same-cycle clear.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      dout <= '0;
      rdy  <= 1'b0;
    end else if (load) begin
      dout <= rx_byte;
      rdy  <= 1'b1;
    end else if (rdy_clr) begin
      rdy  <= 1'b0;
    end
  end

  shift_reg #(
    .INPUT_WIDTH(8),
    .DATA_WIDTH (HDR_WIDTH)
  ) u_hdr (
    .data_out  (header_data),
    .data_in   (rx_byte),
    .clock     (clk_50m),
    .load      (load),
    .shift_byte(1'b0),
    .reset     (reset)
  );

endmodule

// File: tb/tb_uart_shift_link.sv
// Bench for uart_shift_link, run at a reduced clock/baud ratio (16 clocks per bit).
module tb_uart_shift_link;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int HDR    = 640;
  localparam int B      = CLK_HZ / BAUD;

  logic           clk_50m = 1'b0;
  logic           reset;
  logic           rx;
  logic           tx;
  logic [7:0]     din;
  logic           wr_en;
  logic           tx_busy;
  logic [7:0]     dout;
  logic           rdy;
  logic           rdy_clr;
  logic [HDR-1:0] header_data;

  logic           loop_en;
  logic           rx_drv;
  assign rx = loop_en ? tx : rx_drv;

  uart_shift_link #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .HDR_WIDTH(HDR)) dut (
    .clk_50m    (clk_50m),
    .reset      (reset),
    .rx         (rx),
    .tx         (tx),
    .din        (din),
    .wr_en      (wr_en),
    .tx_busy    (tx_busy),
    .dout       (dout),
    .rdy        (rdy),
    .rdy_clr    (rdy_clr),
    .header_data(header_data)
  );

  always #5 clk_50m = ~clk_50m;

  int             n_cmp = 0;
  int             n_bad = 0;
  logic [7:0]     exp_q[$];
  logic [HDR-1:0] exp_hdr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic chk_hdr(input string nm, input logic [HDR-1:0] act, input logic [HDR-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: every delivered byte must match the next queued expectation.
  logic [HDR-1:0] hdr_model;
  logic           prev_rdy;
  logic [7:0]     prev_dout;
  logic [7:0]     e_byte;
  always @(negedge clk_50m) begin
    if (!reset) begin
      hdr_model = '0;
      prev_rdy  = 1'b0;
      prev_dout = 8'h00;
    end else begin
      if ((rdy && !prev_rdy) || (rdy && prev_rdy && dout != prev_dout)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got dout=%h, required no delivery", dout);
        end else begin
          e_byte    = exp_q.pop_front();
          hdr_model = {hdr_model[HDR-9:0], e_byte};
          chk("mon_dout", {56'd0, dout}, {56'd0, e_byte});
          chk_hdr("mon_header", header_data, hdr_model);
        end
      end
      prev_rdy  = rdy;
      prev_dout = dout;
    end
  end

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    exp_hdr = {exp_hdr[HDR-9:0], b};
  endtask

  task automatic wait_tx_idle(input string nm);
    int i;
    for (i = 0; i < 12 * B; i++) begin
      if (!tx_busy) break;
      @(negedge clk_50m);
    end
    chk(nm, {63'd0, tx_busy}, 64'd0);
  endtask

  task automatic send_tx(input logic [7:0] b);
    @(negedge clk_50m);
    din   = b;
    wr_en = 1'b1;
    @(negedge clk_50m);
    wr_en = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk_50m);
    rx_drv = 1'b0;
    repeat (B) @(negedge clk_50m);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (B) @(negedge clk_50m);
    end
    rx_drv = stop;
    repeat (B) @(negedge clk_50m);
    rx_drv = 1'b1;
    repeat (B) @(negedge clk_50m);
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
  endtask

  logic [9:0] a5_bits;

  initial begin
    reset   = 1'b0;
    din     = 8'h00;
    wr_en   = 1'b0;
    rdy_clr = 1'b0;
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    exp_hdr = '0;
    repeat (4) @(negedge clk_50m);
    chk("rst_tx", {63'd0, tx}, 64'd1);
    chk("rst_busy", {63'd0, tx_busy}, 64'd0);
    chk("rst_rdy", {63'd0, rdy}, 64'd0);
    chk("rst_dout", {56'd0, dout}, 64'd0);
    chk_hdr("rst_header", header_data, '0);
    reset = 1'b1;
    repeat (4) @(negedge clk_50m);

    // TX 0xA5: start, 1,0,1,0,0,1,0,1, stop; a mid-frame 0x3C request is dropped.
    a5_bits = 10'b1_1010_0101_0;
    din   = 8'hA5;
    wr_en = 1'b1;
    @(negedge clk_50m);
    wr_en = 1'b0;
    chk("tx_start_busy", {63'd0, tx_busy}, 64'd1);
    chk("tx_start_line", {63'd0, tx}, 64'd0);
    for (int t = 0; t <= 11 * B; t++) begin
      if (t == 3 * B) begin
        din   = 8'h3C;
        wr_en = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      if (t % B == B / 2 && t < 10 * B)
        chk($sformatf("tx_bit%0d", t / B), {63'd0, tx}, {63'd0, a5_bits[t/B]});
      if (t == 10 * B - 1) chk("tx_busy_last", {63'd0, tx_busy}, 64'd1);
      if (t == 10 * B)     chk("tx_busy_fall", {63'd0, tx_busy}, 64'd0);
      if (t == 11 * B)     chk("tx_no_resend", {63'd0, tx}, 64'd1);
      @(negedge clk_50m);
    end

    // Loopback 0x12 then 0x34 back-to-back; second byte overruns the first.
    loop_en = 1'b1;
    expect_byte(8'h12);
    send_tx(8'h12);
    wait_tx_idle("tx_idle_12");
    expect_byte(8'h34);
    send_tx(8'h34);
    wait_tx_idle("tx_idle_34");
    repeat (B) @(negedge clk_50m);
    chk("loop_dout", {56'd0, dout}, 64'h34);
    chk("loop_rdy", {63'd0, rdy}, 64'd1);
    chk("loop_hdr16", {48'd0, header_data[15:0]}, 64'h1234);
    pulse_clr();
    chk("rdy_cleared", {63'd0, rdy}, 64'd0);
    loop_en = 1'b0;

    // Glitch shorter than half a bit is rejected.
    @(negedge clk_50m);
    rx_drv = 1'b0;
    repeat (B / 4) @(negedge clk_50m);
    rx_drv = 1'b1;
    repeat (3 * B) @(negedge clk_50m);
    chk("glitch_rdy", {63'd0, rdy}, 64'd0);

    // Framing error: 0x55 with a low stop bit is discarded.
    send_rx(8'h55, 1'b0);
    repeat (B) @(negedge clk_50m);
    chk("frame_rdy", {63'd0, rdy}, 64'd0);
    chk("frame_dout", {56'd0, dout}, 64'h34);
    chk_hdr("frame_header", header_data, exp_hdr);

    // 81 bytes 0x00..0x50: the first byte falls off the MSB end.
    for (int i = 0; i <= 8'h50; i++) begin
      expect_byte(8'(i));
      send_rx(8'(i), 1'b1);
      pulse_clr();
    end
    chk("wrap_msb", {56'd0, header_data[HDR-1:HDR-8]}, 64'h01);
    chk("wrap_lsb", {56'd0, header_data[7:0]}, 64'h50);
    chk_hdr("wrap_header", header_data, exp_hdr);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-frame in both directions.
    send_tx(8'h00);
    rx_drv = 1'b0;
    repeat (3 * B) @(negedge clk_50m);
    chk("pre_rst_tx_low", {63'd0, tx}, 64'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_tx", {63'd0, tx}, 64'd1);
    chk("midrst_busy", {63'd0, tx_busy}, 64'd0);
    chk_hdr("midrst_header", header_data, '0);
    rx_drv = 1'b1;
    repeat (2) @(negedge clk_50m);
    reset = 1'b1;
    repeat (12 * B) @(negedge clk_50m);
    chk("midrst_rdy", {63'd0, rdy}, 64'd0);
    chk("midrst_dout", {56'd0, dout}, 64'd0);
    chk("midrst_queue", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
